// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - control/status bundle between the PC sequencer and its neighbours
interface pc_sequencer_if #(
  parameter int XLEN   = 32,
  parameter int IMM_W  = 16,
  parameter int ADDR_W = 26
) ();
  logic              Stall;
  logic              Resume;
  logic [2:0]        PCSrc;
  logic [IMM_W-1:0]  Immediate;
  logic [ADDR_W-1:0] Address;
  logic [XLEN-1:0]   RegTarget;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   NewPC;
  logic              Halted;
  logic              RasEmpty;
  logic              RasFull;
  logic              RasOverflow;
  logic              RasUnderflow;

  modport master (
    output Stall, Resume, PCSrc, Immediate, Address, RegTarget,
    input  pc, NewPC, Halted, RasEmpty, RasFull, RasOverflow, RasUnderflow
  );

  modport slave (
    input  Stall, Resume, PCSrc, Immediate, Address, RegTarget,
    output pc, NewPC, Halted, RasEmpty, RasFull, RasOverflow, RasUnderflow
  );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter with branch/jump/call/return, stall hold and halt/resume
module pc_sequencer #(
  parameter int              XLEN         = 32,
  parameter int              IMM_W        = 16,
  parameter int              ADDR_W       = 26,
  parameter int              RAS_DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic             CLK,
  input  logic             Reset,
  pc_sequencer_if.slave    bus
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] SRC_NEXT = 3'b000;
  localparam logic [2:0] SRC_REL  = 3'b001;
  localparam logic [2:0] SRC_ABS  = 3'b010;
  localparam logic [2:0] SRC_HALT = 3'b011;
  localparam logic [2:0] SRC_CALL = 3'b100;
  localparam logic [2:0] SRC_RET  = 3'b101;
  localparam logic [2:0] SRC_REG  = 3'b110;

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t            state, next_state;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   new_pc;
  logic              push, pop;
  logic [PTR_W-1:0]  ras_top_q;
  logic [CNT_W-1:0]  ras_count_q;
  logic [XLEN-1:0]   ras_mem [RAS_DEPTH];
  logic              overflow_q, underflow_q;

  logic [XLEN-1:0]   pc_plus4;
  logic [XLEN-1:0]   rel_target;
  logic [XLEN-1:0]   abs_target;
  logic [PTR_W-1:0]  push_slot;
  logic              ras_empty, ras_full;

  assign pc_plus4   = pc_q + XLEN'(4);
  assign rel_target = pc_plus4 + ({{(XLEN-IMM_W){bus.Immediate[IMM_W-1]}}, bus.Immediate} << 2);
  assign abs_target = {pc_q[XLEN-1:ADDR_W+2], bus.Address, 2'b00};
  assign push_slot  = ras_top_q + PTR_W'(1);
  assign ras_empty  = (ras_count_q == '0);
  assign ras_full   = (ras_count_q == CNT_W'(RAS_DEPTH));

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state <= RUN;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (!bus.Stall) begin
      if (state == RUN && bus.PCSrc == SRC_HALT) next_state = HALTED;
      else if (state == HALTED && bus.Resume)    next_state = RUN;
    end
  end

  // Stall is applied last so it overrides both Resume and any PCSrc redirect.
  always_comb begin
    new_pc = pc_q;
    push   = 1'b0;
    pop    = 1'b0;
    if (state == HALTED) begin
      if (bus.Resume) new_pc = pc_plus4;
    end else begin
      case (bus.PCSrc)
        SRC_REL:  new_pc = rel_target;
        SRC_ABS:  new_pc = abs_target;
        SRC_HALT: new_pc = pc_q;
        SRC_CALL: begin
          new_pc = abs_target;
          push   = 1'b1;
        end
        SRC_RET: begin
          new_pc = ras_empty ? bus.RegTarget : ras_mem[ras_top_q];
          pop    = 1'b1;
        end
        SRC_REG:  new_pc = bus.RegTarget;
        default:  new_pc = pc_plus4;
      endcase
    end
    if (bus.Stall) begin
      new_pc = pc_q;
      push   = 1'b0;
      pop    = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) pc_q <= RESET_VECTOR;
    else        pc_q <= new_pc;
  end

  // A push while full simply advances the ring, overwriting the oldest entry.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      ras_top_q   <= '0;
      ras_count_q <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (push) begin
      ras_top_q <= push_slot;
      if (ras_full) overflow_q  <= 1'b1;
      else          ras_count_q <= ras_count_q + CNT_W'(1);
    end else if (pop) begin
      if (ras_empty) begin
        underflow_q <= 1'b1;
      end else begin
        ras_top_q   <= ras_top_q - PTR_W'(1);
        ras_count_q <= ras_count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) ras_mem[push_slot] <= pc_plus4;
  end

  assign bus.pc           = pc_q;
  assign bus.NewPC        = new_pc;
  assign bus.Halted       = (state == HALTED);
  assign bus.RasEmpty     = ras_empty;
  assign bus.RasFull      = ras_full;
  assign bus.RasOverflow  = overflow_q;
  assign bus.RasUnderflow = underflow_q;
endmodule
